// File: rtl/arm_ctrl_pkg.sv
// arm_ctrl_pkg: shared encodings for the ARM ID-stage control path.
package arm_ctrl_pkg;
    localparam logic [1:0] OP_DP = 2'b00;
    localparam logic [1:0] OP_LS = 2'b01;
    localparam logic [1:0] OP_BR = 2'b10;
    localparam logic [3:0] OPC_AND = 4'b0000;
    localparam logic [3:0] OPC_SUB = 4'b0010;
    localparam logic [3:0] OPC_ADD = 4'b0100;
    localparam logic [3:0] OPC_ORR = 4'b1100;
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;
    localparam int OP_HI   = 27;
    localparam int OP_LO   = 26;
    localparam int I_BIT   = 25;
    localparam int OPC_HI  = 24;
    localparam int OPC_LO  = 21;
    localparam int S_BIT   = 20;
    localparam int U_BIT   = 23;
    localparam int LNK_BIT = 24;
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [1:0] s_bit;
        logic [1:0] alu_control;
        logic       pc_src;
    } ctrl_t;
    function automatic logic dp_valid(input logic [3:0] opc);
        return opc == OPC_AND || opc == OPC_SUB || opc == OPC_ADD || opc == OPC_ORR;
    endfunction
    function automatic logic [1:0] dp_alu(input logic [3:0] opc);
        return opc == OPC_ADD ? ALU_ADD :
               opc == OPC_SUB ? ALU_SUB :
               opc == OPC_AND ? ALU_AND : ALU_ORR;
    endfunction
endpackage

// File: rtl/id_control_unit_adder.sv
// adder: modular unsigned adder used as the PC incrementer.
module adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o
);
    assign sum_o = a_i + b_i;
endmodule

// File: rtl/id_control_unit_decoder.sv
// control_decoder: combinational instruction-to-control decode.
module control_decoder
    import arm_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] instr_i,
    output ctrl_t            ctrl_o
);
    logic [3:0] opc;
    assign opc = instr_i[OPC_HI:OPC_LO];
    always_comb begin
        ctrl_o = '0;
        if (instr_i != '0) begin
            case (instr_i[OP_HI:OP_LO])
                OP_DP: if (dp_valid(opc)) begin
                    ctrl_o.reg_write   = 1'b1;
                    ctrl_o.alu_src     = instr_i[I_BIT];
                    ctrl_o.s_bit       = {1'b0, instr_i[S_BIT]};
                    ctrl_o.alu_control = dp_alu(opc);
                end
                OP_LS: begin
                    ctrl_o.alu_src     = ~instr_i[I_BIT];
                    ctrl_o.alu_control = instr_i[U_BIT] ? ALU_ADD : ALU_SUB;
                    ctrl_o.reg_write   = instr_i[S_BIT];
                    ctrl_o.mem_to_reg  = instr_i[S_BIT];
                    ctrl_o.mem_write   = ~instr_i[S_BIT];
                    ctrl_o.s_bit       = instr_i[S_BIT] ? 2'b00 : 2'b10;
                end
                OP_BR: begin
                    ctrl_o.pc_src    = 1'b1;
                    ctrl_o.reg_write = instr_i[LNK_BIT];
                end
                default: ctrl_o = '0;
            endcase
        end
    end
endmodule

// File: rtl/id_control_unit.sv
// id_control_unit: IF/ID instruction latch, control decode with bubble mux, and PC incrementer.
module id_control_unit
    import arm_ctrl_pkg::*;
#(
    parameter int          WIDTH  = 32,
    parameter int unsigned PC_INC = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_id_enable,
    input  logic [WIDTH-1:0] instruction_in,
    input  logic [WIDTH-1:0] pc_current,
    input  logic             bubble,
    output logic [WIDTH-1:0] pc_plus_4,
    output logic [WIDTH-1:0] instruction_out,
    output logic             reg_write,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             alu_src,
    output logic [1:0]       s_bit,
    output logic [1:0]       alu_control,
    output logic             pc_src
);
    logic [WIDTH-1:0] instr_q, instr_d;
    ctrl_t            dec, ctrl;
    assign instr_d = if_id_enable ? instruction_in : instr_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) instr_q <= '0;
        else       instr_q <= instr_d;
    end
    assign instruction_out = instr_q;
    control_decoder #(.WIDTH(WIDTH)) u_decoder (
        .instr_i (instr_q),
        .ctrl_o  (dec)
    );
    // Bubble squashes controls only; the latched instruction is kept.
    assign ctrl = bubble ? '0 : dec;
    assign {reg_write, mem_write, mem_to_reg, alu_src, s_bit, alu_control, pc_src} = ctrl;
    adder #(.WIDTH(WIDTH)) u_adder (
        .a_i   (pc_current),
        .b_i   (WIDTH'(PC_INC)),
        .sum_o (pc_plus_4)
    );
endmodule

// File: tb/tb_id_control_unit.sv
// tb_id_control_unit: scoreboard bench for the ID-stage control unit.
module tb_id_control_unit;
    logic        clk = 1'b0;
    logic        reset, if_id_enable, bubble;
    logic [31:0] instruction_in, pc_current, pc_plus_4, instruction_out;
    logic        reg_write, mem_write, mem_to_reg, alu_src, pc_src;
    logic [1:0]  s_bit, alu_control;
    logic [8:0]  ctrl;
    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [8:0]  ctrl;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    int total = 0;
    int passed = 0;
    // {reg_write, mem_write, mem_to_reg, alu_src, s_bit, alu_control, pc_src}
    localparam logic [8:0] C_ANDS = 9'b1_0_0_1_01_10_0;
    localparam logic [8:0] C_ADD  = 9'b1_0_0_0_00_00_0;
    localparam logic [8:0] C_LDRB = 9'b1_0_1_0_00_00_0;
    localparam logic [8:0] C_STR  = 9'b0_1_0_1_10_00_0;
    localparam logic [8:0] C_BNE  = 9'b0_0_0_0_00_00_1;
    localparam logic [8:0] C_BLLE = 9'b1_0_0_0_00_00_1;
    localparam logic [8:0] C_ORR  = 9'b1_0_0_0_00_11_0;
    localparam logic [8:0] C_SUBS = 9'b1_0_0_1_01_01_0;
    localparam logic [8:0] C_LDRN = 9'b1_0_1_1_00_01_0;
    assign ctrl = {reg_write, mem_write, mem_to_reg, alu_src, s_bit, alu_control, pc_src};
    always #5 clk = ~clk;
    id_control_unit dut (
        .clk             (clk),
        .reset           (reset),
        .if_id_enable    (if_id_enable),
        .instruction_in  (instruction_in),
        .pc_current      (pc_current),
        .bubble          (bubble),
        .pc_plus_4       (pc_plus_4),
        .instruction_out (instruction_out),
        .reg_write       (reg_write),
        .mem_write       (mem_write),
        .mem_to_reg      (mem_to_reg),
        .alu_src         (alu_src),
        .s_bit           (s_bit),
        .alu_control     (alu_control),
        .pc_src          (pc_src)
    );
    task automatic push(input string n, input logic [31:0] i, input logic [8:0] c);
        exp_t x;
        x.name = n;
        x.instr = i;
        x.ctrl = c;
        sb.push_back(x);
    endtask
    task automatic test_reset;
        reset = 1'b1;
        bubble = 1'b0;
        if_id_enable = 1'b1;
        instruction_in = 32'hE2110000;
        pc_current = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        if_id_enable = 1'b0;
        reset = 1'b0;
        push("reset", 32'h0, 9'h0);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        total++;
        if (instruction_out !== e.instr || ctrl !== e.ctrl)
            $display("FAIL %s: instr=%h ctrl=%b, expected instr=%h ctrl=%b", e.name, instruction_out, ctrl, e.instr, e.ctrl);
        else passed++;
        total++;
        if (pc_plus_4 !== 32'h4) $display("FAIL pc_zero: got %h expected 00000004", pc_plus_4);
        else passed++;
        pc_current = 32'hFFFFFFFC;
        #1;
        total++;
        if (pc_plus_4 !== 32'h0) $display("FAIL pc_wrap: got %h expected 00000000", pc_plus_4);
        else passed++;
    endtask
    task automatic test_adder;
        logic [31:0] pcs [3] = '{32'h7FFFFFFC, 32'h00001000, 32'hFFFFFFFF};
        logic [31:0] exps[3] = '{32'h80000000, 32'h00001004, 32'h00000003};
        for (int i = 0; i < 3; i++) begin
            pc_current = pcs[i];
            #1;
            total++;
            if (pc_plus_4 !== exps[i]) $display("FAIL pc_inc%0d: got %h expected %h", i, pc_plus_4, exps[i]);
            else passed++;
        end
    endtask
    task automatic test_back_to_back;
        logic [31:0] ins[13] = '{32'hE2110000, 32'hE0805183, 32'hE7D12000, 32'hE58A5000,
                                 32'h1AFFFFFD, 32'hDB000009, 32'hE1810002, 32'hE2500001,
                                 32'hE5112004, 32'hE1A00000, 32'hEE000000, 32'h00000000,
                                 32'hE2110000};
        logic [8:0]  cs[13]  = '{C_ANDS, C_ADD, C_LDRB, C_STR, C_BNE, C_BLLE, C_ORR, C_SUBS,
                                 C_LDRN, 9'h0, 9'h0, 9'h0, C_ANDS};
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            instruction_in = ins[i];
            if_id_enable = 1'b1;
            push($sformatf("decode%0d", i), ins[i], cs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            total++;
            if (instruction_out !== e.instr || ctrl !== e.ctrl)
                $display("FAIL %s: instr=%h ctrl=%b, expected instr=%h ctrl=%b", e.name, instruction_out, ctrl, e.instr, e.ctrl);
            else passed++;
        end
    endtask
    task automatic test_hold;
        @(negedge clk);
        if_id_enable = 1'b0;
        instruction_in = 32'hE58A5000;
        push("hold", 32'hE2110000, C_ANDS);
        repeat (2) @(posedge clk);
        #1;
        e = sb.pop_front();
        total++;
        if (instruction_out !== e.instr || ctrl !== e.ctrl)
            $display("FAIL %s: instr=%h ctrl=%b, expected instr=%h ctrl=%b", e.name, instruction_out, ctrl, e.instr, e.ctrl);
        else passed++;
    endtask
    task automatic test_bubble;
        @(negedge clk);
        bubble = 1'b1;
        push("bubble_ands", 32'hE2110000, 9'h0);
        #1;
        e = sb.pop_front();
        total++;
        if (instruction_out !== e.instr || ctrl !== e.ctrl)
            $display("FAIL %s: instr=%h ctrl=%b, expected instr=%h ctrl=%b", e.name, instruction_out, ctrl, e.instr, e.ctrl);
        else passed++;
        instruction_in = 32'hE0805183;
        if_id_enable = 1'b1;
        push("bubble_latch", 32'hE0805183, 9'h0);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        total++;
        if (instruction_out !== e.instr || ctrl !== e.ctrl)
            $display("FAIL %s: instr=%h ctrl=%b, expected instr=%h ctrl=%b", e.name, instruction_out, ctrl, e.instr, e.ctrl);
        else passed++;
        @(negedge clk);
        bubble = 1'b0;
        if_id_enable = 1'b0;
        push("bubble_release", 32'hE0805183, C_ADD);
        #1;
        e = sb.pop_front();
        total++;
        if (instruction_out !== e.instr || ctrl !== e.ctrl)
            $display("FAIL %s: instr=%h ctrl=%b, expected instr=%h ctrl=%b", e.name, instruction_out, ctrl, e.instr, e.ctrl);
        else passed++;
    endtask
    task automatic test_reset_mid;
        @(posedge clk);
        #3;
        reset = 1'b1;
        push("reset_async", 32'h0, 9'h0);
        #1;
        e = sb.pop_front();
        total++;
        if (instruction_out !== e.instr || ctrl !== e.ctrl)
            $display("FAIL %s: instr=%h ctrl=%b, expected instr=%h ctrl=%b", e.name, instruction_out, ctrl, e.instr, e.ctrl);
        else passed++;
        bubble = 1'b1;
        push("reset_bubble", 32'h0, 9'h0);
        #1;
        e = sb.pop_front();
        total++;
        if (instruction_out !== e.instr || ctrl !== e.ctrl)
            $display("FAIL %s: instr=%h ctrl=%b, expected instr=%h ctrl=%b", e.name, instruction_out, ctrl, e.instr, e.ctrl);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        bubble = 1'b0;
        if_id_enable = 1'b0;
        instruction_in = 32'hDB000009;
        push("post_reset_hold", 32'h0, 9'h0);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        total++;
        if (instruction_out !== e.instr || ctrl !== e.ctrl)
            $display("FAIL %s: instr=%h ctrl=%b, expected instr=%h ctrl=%b", e.name, instruction_out, ctrl, e.instr, e.ctrl);
        else passed++;
        @(negedge clk);
        if_id_enable = 1'b1;
        push("post_reset_load", 32'hDB000009, C_BLLE);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        total++;
        if (instruction_out !== e.instr || ctrl !== e.ctrl)
            $display("FAIL %s: instr=%h ctrl=%b, expected instr=%h ctrl=%b", e.name, instruction_out, ctrl, e.instr, e.ctrl);
        else passed++;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, got timeout expected finish");
        $fatal(1);
    end
    initial begin
        test_reset();
        test_adder();
        test_back_to_back();
        test_hold();
        test_bubble();
        test_reset_mid();
        total++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
